// File: rtl/instr_issue_sequencer.sv
// rtl/instr_issue_sequencer.sv - instruction buffer and issue sequencer feeding the single-cycle core
module instr_issue_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          CLK,
   input  logic          ResetPC,
   input  logic          LoadEn,
   input  logic [AW-1:0] LoadAddr,
   input  logic [31:0]   LoadData,
   input  logic [AW:0]   ProgLen,
   input  logic          Start,
   input  logic          Halt,
   input  logic          Step,
   input  logic          BranchTaken,
   input  logic [12:0]   BranchOffset,
   output logic [31:0]   Instruction,
   output logic          InstrValid,
   output logic [31:0]   CorePC,
   output logic          CoreResetPC,
   output logic [2:0]    State,
   output logic          Done,
   output logic          Error,
   output logic [15:0]   RetiredCount
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_STEP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] mem [DEPTH];

   state_t      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        crst_q, crst_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic        taken;
   logic [31:0] target;
   logic [31:0] limit;
   logic        end_hit;
   logic        bad;
   logic        advance;
   logic        park;

   // Branch outcome only matters for an instruction the core is actually executing
   always_comb begin
      taken   = valid_q & BranchTaken;
      target  = pc_q;
      if (taken)
         target = pc_q + {{19{BranchOffset[12]}}, BranchOffset};
      else if (valid_q)
         target = pc_q + 32'd4;
      limit   = 32'(ProgLen) << 2;
      end_hit = (target >= limit);
      bad     = taken & (end_hit | (target[1:0] != 2'b00));
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      crst_d  = crst_q;
      done_d  = done_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      advance = 1'b0;
      park    = 1'b0;

      if (valid_q && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start && (ProgLen != '0)) begin
               state_d = S_RUN;
               pc_d    = 32'd0;
               valid_d = 1'b0;
               instr_d = NOP;
               cnt_d   = 16'd0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               crst_d  = 1'b1;
            end
         end
         S_RUN: begin
            crst_d = 1'b0;
            if (Halt)
               park = 1'b1;
            else
               advance = 1'b1;
         end
         S_PAUSE: begin
            if (!Halt) begin
               if (Step)
                  advance = 1'b1;
               else if (Start)
                  state_d = S_RUN;
            end
         end
         S_STEP: park = 1'b1;
         default: state_d = S_IDLE;
      endcase

      // Every edge that moves the PC passes through the end-of-program check first
      if (advance || park) begin
         if (end_hit || bad) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = bad;
            valid_d = 1'b0;
            instr_d = NOP;
         end else if (advance) begin
            state_d = (state_q == S_PAUSE) ? S_STEP : S_RUN;
            instr_d = mem[target[AW+1:2]];
            pc_d    = target;
            valid_d = 1'b1;
         end else begin
            state_d = S_PAUSE;
            pc_d    = target;
            valid_d = 1'b0;
            instr_d = NOP;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (ResetPC) begin
         state_q <= S_IDLE;
         instr_q <= NOP;
         pc_q    <= 32'd0;
         valid_q <= 1'b0;
         crst_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         crst_q  <= crst_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Buffer survives reset; host writes only while nothing is being issued
   always_ff @(posedge CLK) begin
      if (LoadEn && ((state_q == S_IDLE) || (state_q == S_DONE)))
         mem[LoadAddr] <= LoadData;
   end

   assign Instruction  = instr_q;
   assign InstrValid   = valid_q;
   assign CorePC       = pc_q;
   assign CoreResetPC  = crst_q;
   assign State        = state_q;
   assign Done         = done_q;
   assign Error        = err_q;
   assign RetiredCount = cnt_q;

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// tb/tb_instr_issue_sequencer.sv - scoreboard bench for instr_issue_sequencer
module tb_instr_issue_sequencer;

   localparam int AW = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      bit taken;
      int off;
   } dec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   logic          CLK = 1'b0;
   logic          ResetPC;
   logic          LoadEn;
   logic [AW-1:0] LoadAddr;
   logic [31:0]   LoadData;
   logic [AW:0]   ProgLen;
   logic          Start;
   logic          Halt;
   logic          Step;
   logic          BranchTaken = 1'b0;
   logic [12:0]   BranchOffset = 13'd0;
   logic [31:0]   Instruction;
   logic          InstrValid;
   logic [31:0]   CorePC;
   logic          CoreResetPC;
   logic [2:0]    State;
   logic          Done;
   logic          Error;
   logic [15:0]   RetiredCount;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem_m [16];
   dec_t        dec_q[$];
   dec_t        plan_q[$];
   exp_t        exp_q[$];
   int          exp_cnt;
   bit          exp_err;
   logic [31:0] exp_last;
   dec_t        drv_d;
   exp_t        mon_e;

   always #5 CLK = ~CLK;

   instr_issue_sequencer #(.DEPTH(16), .AW(AW)) dut (
      .CLK(CLK), .ResetPC(ResetPC), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
      .LoadData(LoadData), .ProgLen(ProgLen), .Start(Start), .Halt(Halt),
      .Step(Step), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
      .Instruction(Instruction), .InstrValid(InstrValid), .CorePC(CorePC),
      .CoreResetPC(CoreResetPC), .State(State), .Done(Done), .Error(Error),
      .RetiredCount(RetiredCount)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Core stand-in: answers each presented instruction with the planned branch outcome
   always @(posedge CLK) begin
      #1;
      if (InstrValid === 1'b1 && plan_q.size() > 0) begin
         drv_d        = plan_q.pop_front();
         BranchTaken  = drv_d.taken;
         BranchOffset = drv_d.taken ? 13'(drv_d.off) : 13'($urandom);
      end else begin
         BranchTaken  = 1'($urandom);
         BranchOffset = 13'($urandom);
      end
   end

   always @(negedge CLK) begin
      if (InstrValid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_issue_pc", CorePC, 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check("issue_pc", CorePC, mon_e.pc);
            check("issue_instr", Instruction, mon_e.ins);
         end
      end
   end

   // Program-level walk: which addresses the core sees, and how the run ends
   task automatic model_walk(input int len);
      logic [31:0] pc, nxt, lim;
      dec_t d;
      pc = 32'd0;
      exp_cnt = 0;
      exp_err = 0;
      lim = 32'(len) * 32'd4;
      forever begin
         exp_q.push_back('{pc, mem_m[pc[5:2]]});
         exp_cnt++;
         exp_last = pc;
         if (dec_q.size() > 0) d = dec_q.pop_front();
         else d = '{0, 0};
         plan_q.push_back(d);
         nxt = d.taken ? pc + 32'(d.off) : pc + 32'd4;
         if (nxt >= lim) begin
            exp_err = d.taken;
            break;
         end
         if (d.taken && (nxt % 4 != 0)) begin
            exp_err = 1;
            break;
         end
         pc = nxt;
      end
   endtask

   task automatic load_all();
      for (int i = 0; i < 16; i++) begin
         LoadEn = 1'b1;
         LoadAddr = 4'(i);
         LoadData = mem_m[i];
         tick();
      end
      LoadEn = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(State), 32'd0);
      check({tag, "_instr"}, Instruction, NOP);
      check({tag, "_valid"}, 32'(InstrValid), 32'd0);
      check({tag, "_pc"}, CorePC, 32'd0);
      check({tag, "_corereset"}, 32'(CoreResetPC), 32'd1);
      check({tag, "_done"}, 32'(Done), 32'd0);
      check({tag, "_error"}, 32'(Error), 32'd0);
      check({tag, "_retired"}, 32'(RetiredCount), 32'd0);
   endtask

   task automatic start_prog(input int len, input bit load0);
      exp_q.delete();
      plan_q.delete();
      model_walk(len);
      ProgLen = 5'(len);
      if (load0) begin
         LoadEn = 1'b1;
         LoadAddr = 4'd0;
         LoadData = mem_m[0];
      end
      Start = 1'b1;
      tick();
      Start = 1'b0;
      LoadEn = 1'b0;
      check("start_state", 32'(State), 32'd1);
      check("start_corereset", 32'(CoreResetPC), 32'd1);
      check("start_valid", 32'(InstrValid), 32'd0);
      check("start_retired", 32'(RetiredCount), 32'd0);
   endtask

   task automatic finish_prog();
      for (int i = 0; i < 300 && Done !== 1'b1; i++) tick();
      check("end_done", 32'(Done), 32'd1);
      check("end_error", 32'(Error), 32'(exp_err));
      check("end_state", 32'(State), 32'd4);
      check("end_retired", 32'(RetiredCount), 32'(exp_cnt));
      check("end_valid", 32'(InstrValid), 32'd0);
      check("end_instr", Instruction, NOP);
      check("end_pc", CorePC, exp_last);
      check("end_corereset", 32'(CoreResetPC), 32'd0);
      check("end_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_prog(input int len, input bit load0);
      start_prog(len, load0);
      finish_prog();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ResetPC = 1'b1;
      LoadEn = 1'b0;
      LoadAddr = '0;
      LoadData = '0;
      ProgLen = '0;
      Start = 1'b0;
      Halt = 1'b0;
      Step = 1'b0;
      tick();
      tick();
      ResetPC = 1'b0;
      check_reset_values("reset");

      // Start with empty program and Step are both ignored in IDLE
      Start = 1'b1;
      Step = 1'b1;
      tick();
      Start = 1'b0;
      Step = 1'b0;
      check("idle_ignore_state", 32'(State), 32'd0);
      check("idle_ignore_corereset", 32'(CoreResetPC), 32'd1);

      for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
      mem_m[0] = 32'h0050_0093;
      mem_m[1] = 32'h0070_0113;
      mem_m[2] = 32'h0020_81B3;
      mem_m[3] = 32'h0000_0013;
      load_all();

      dec_q.delete();
      run_prog(4, 0);

      dec_q.delete();
      dec_q.push_back('{1, 8});
      run_prog(4, 0);

      dec_q.delete();
      dec_q.push_back('{1, -4});
      run_prog(4, 0);

      // Halt / Step / resume
      dec_q.delete();
      start_prog(4, 0);
      tick();
      tick();
      check("pre_halt_pc", CorePC, 32'd4);
      Halt = 1'b1;
      tick();
      Halt = 1'b0;
      check("halt_state", 32'(State), 32'd2);
      check("halt_instr", Instruction, NOP);
      check("halt_valid", 32'(InstrValid), 32'd0);
      check("halt_pc", CorePC, 32'd8);
      Step = 1'b1;
      tick();
      Step = 1'b0;
      check("step_state", 32'(State), 32'd3);
      check("step_pc", CorePC, 32'd8);
      check("step_valid", 32'(InstrValid), 32'd1);
      tick();
      check("step_back_state", 32'(State), 32'd2);
      check("step_back_pc", CorePC, 32'd12);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("resume_state", 32'(State), 32'd1);
      finish_prog();

      // Reset mid-run, with a host write attempted while running
      dec_q.delete();
      start_prog(4, 0);
      tick();
      tick();
      LoadEn = 1'b1;
      LoadAddr = 4'd1;
      LoadData = 32'hDEAD_BEEF;
      tick();
      LoadEn = 1'b0;
      check("midrun_pc", CorePC, 32'd8);
      ResetPC = 1'b1;
      tick();
      ResetPC = 1'b0;
      check_reset_values("midrun_reset");
      run_prog(4, 0);

      for (int it = 0; it < 25; it++) begin
         int len;
         int nd;
         bit load0;
         len = int'($urandom_range(1, 16));
         for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
         load_all();
         dec_q.delete();
         nd = int'($urandom_range(0, 10));
         for (int k = 0; k < nd; k++) begin
            dec_t d;
            int r;
            d.taken = ($urandom % 3 == 0);
            r = int'($urandom % 10);
            if (r < 7) d.off = 4 * int'($urandom_range(0, 8)) - 16;
            else if (r < 9) d.off = 4 * int'($urandom_range(0, 8)) - 14;
            else d.off = 4 * int'($urandom_range(8, 40));
            dec_q.push_back(d);
         end
         load0 = 1'($urandom);
         if (load0) mem_m[0] = $urandom;
         run_prog(len, load0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_issue_sequencer.md
Name: instr_issue_sequencer

Overview:
- Program sequencer in front of the single-cycle RISC-V core. Holds a small instruction buffer loaded by a host, then drives the core's Instruction input one instruction per CLK.
- Redirects on branches reported by the core, and supports run, halt, single-step and completion/error detection.
- Replaces hand-driven instruction stimulus for system-level bring-up.

Parameters:
DEPTH, 16, instruction buffer entries (32-bit words)
AW, 4, buffer index width, log2(DEPTH)

Ports:
CLK  input  1  system clock, rising edge
ResetPC  input  1  synchronous active-high reset
LoadEn  input  1  host write strobe for buffer
LoadAddr  input  AW  buffer word index
LoadData  input  32  instruction word to store
ProgLen  input  AW+1  program length in words, 0..DEPTH
Start  input  1  start from PC 0, or resume from PAUSE
Halt  input  1  stop issuing, enter PAUSE
Step  input  1  issue exactly one instruction from PAUSE
BranchTaken  input  1  core: presented instruction's branch is taken
BranchOffset  input  13  core: signed byte offset of taken branch
Instruction  output  32  instruction presented to core
InstrValid  output  1  Instruction is a real program instruction
CorePC  output  32  byte address of presented instruction
CoreResetPC  output  1  reset request to core
State  output  3  IDLE=0 RUN=1 PAUSE=2 STEP=3 DONE=4
Done  output  1  program finished (sticky until Start/reset)
Error  output  1  illegal branch target (sticky until Start/reset)
RetiredCount  output  16  instructions issued since Start, saturating

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-high on ResetPC. All outputs are registered.
- Reset values: State=IDLE, Instruction=32'h00000013 (NOP), InstrValid=0, CorePC=0, CoreResetPC=1, Done=0, Error=0, RetiredCount=0.
- Buffer contents are not cleared by reset.
- Buffer write: LoadEn is honoured only in IDLE or DONE and writes mem[LoadAddr]<=LoadData. It is ignored in RUN/PAUSE/STEP.
- Target (combinational):
  - If InstrValid=0: Target=CorePC.
  - If InstrValid=1 and BranchTaken=1: Target=CorePC+sext32(BranchOffset), 32-bit wraparound.
  - Otherwise: Target=CorePC+4.
  - BranchTaken is ignored while InstrValid=0.
- Issue edge (RUN, or PAUSE+Step):
  - Instruction<=mem[Target[AW+1:2]], CorePC<=Target, InstrValid<=1.
  - RetiredCount increments at every edge where InstrValid=1 (saturates at 16'hFFFF).
- End check, evaluated at every issue edge before issuing:
  - Sequential Target >= 4*ProgLen: go to DONE, Done<=1.
  - Taken-branch Target >= 4*ProgLen, or Target[1:0]!=0: go to DONE, Done<=1, Error<=1.
  - On entry to DONE: InstrValid<=0, Instruction<=NOP, CorePC holds the last presented address.
- IDLE:
  - Start with ProgLen!=0: go to RUN, CorePC<=0, InstrValid<=0, RetiredCount<=0, Done<=0, Error<=0, CoreResetPC stays 1 for this first RUN cycle.
  - Start with ProgLen=0 is ignored.
  - Step is ignored.
- RUN: CoreResetPC<=0 and one issue per edge. The first instruction (PC 0) appears one edge after the Start edge.
- Halt in RUN: go to PAUSE, CorePC<=Target, InstrValid<=0, Instruction<=NOP. The end check still applies; if it fires, go to DONE instead.
- PAUSE:
  - Step: go to STEP and perform one issue edge.
  - Start: go to RUN, no clearing of counters.
- STEP: the next edge returns to PAUSE, CorePC<=Target, InstrValid<=0. The end check applies.
- DONE:
  - Start (ProgLen!=0) behaves as Start from IDLE, with CoreResetPC<=1 for one cycle.
  - Halt and Step are ignored.
- Simultaneous controls: priority is Halt > Step > Start. LoadEn together with Start in IDLE: the write lands first, and the first read occurs on the next edge, so it sees the new data.
- ResetPC mid-operation: return to the reset values immediately at that edge; buffer is retained.

Test Plan:
1. Reset -> State=0, Instruction=0x00000013, InstrValid=0, CoreResetPC=1, RetiredCount=0.
2. Load 0x00500093, 0x00700113, 0x002081B3, 0x00000013 at 0..3, ProgLen=4, Start, BranchTaken=0 -> CorePC 0,4,8,12 on consecutive cycles with matching Instruction, then Done=1, Error=0, State=4, RetiredCount=4.
3. Same program, BranchTaken=1 with BranchOffset=8 while CorePC=0 -> next CorePC=8, then 12, then Done=1, RetiredCount=3.
4. BranchTaken=1 with BranchOffset=-4 (13'h1FFC) at CorePC=0 -> State=DONE, Error=1, Done=1, RetiredCount=1, InstrValid=0.
5. Halt while CorePC=4 valid -> PAUSE, Instruction=NOP; Step -> one cycle with CorePC=8, back to PAUSE; Start -> CorePC=12, then Done.
6. ResetPC asserted mid-RUN at CorePC=8 -> reset values next edge; Start again -> reruns from CorePC=0 with the retained buffer. LoadEn in RUN leaves mem unchanged (verify by rerun).
